if_id_hazard_ctrl: RTL and testbench

Front-end pipeline controller for the RISC-V core. It sequences the IF/ID pipeline register and the program counter by producing the PC write enable, the IF/ID write enable and flush, the ID/EX bubble and the EX hold. It arbitrates four sources of disturbance: taken branches resolved in EX, multi-cycle mul/div in EX, load-use hazards, and a ready-handshaked instruction memory. It also counts stall cycles for performance monitoring.

---
 rtl/if_id_hazard_ctrl_pkg.sv | 23 ++
 rtl/if_id_hazard_ctrl_load_use_detect.sv | 30 +++
 rtl/if_id_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_if_id_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_hazard_ctrl_pkg
// Description : Shared front-end control definitions: controller state
//               encoding, default widths/latencies and the x0 index.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_hazard_ctrl_pkg;

  localparam int REG_ADDR_LEN_DEF = 5;
  localparam int MD_LATENCY_DEF   = 4;

  // Register x0 is hard-wired to zero, so it never carries a real dependency.
  localparam int X0_IDX = 0;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_e;

endpackage : if_id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/if_id_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a load in ID/EX whose destination feeds a source
//               operand of the instruction in IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import if_id_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF
) (
  input  logic                    mem_read_i,
  input  logic [REG_ADDR_LEN-1:0] rd_i,
  input  logic [REG_ADDR_LEN-1:0] rs1_i,
  input  logic [REG_ADDR_LEN-1:0] rs2_i,
  input  logic                    uses_rs2_i,
  output logic                    hazard_o
);

  localparam logic [REG_ADDR_LEN-1:0] X0 = REG_ADDR_LEN'(X0_IDX);

  // rs2 only matters when the consumer actually reads it.
  always_comb begin
    hazard_o = mem_read_i && (rd_i != X0) &&
               ((rd_i == rs1_i) || (uses_rs2_i && (rd_i == rs2_i)));
  end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/if_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_id_hazard_ctrl
// Description : Front-end pipeline controller. Arbitrates branch redirect,
//               mul/div hold, load-use bubbles and instruction-memory wait
//               states, and counts front-end stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_hazard_ctrl
  import if_id_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN    = REG_ADDR_LEN_DEF,
  parameter int MD_LATENCY      = MD_LATENCY_DEF,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_taken,
  input  logic                       ex_is_muldiv,
  input  logic                       id_ex_mem_read,
  input  logic [REG_ADDR_LEN-1:0]    id_ex_rd,
  input  logic [REG_ADDR_LEN-1:0]    if_id_rs1,
  input  logic [REG_ADDR_LEN-1:0]    if_id_rs2,
  input  logic                       if_id_uses_rs2,
  input  logic                       imem_ready,
  output logic                       imem_req,
  output logic                       PC_WRITE,
  output logic                       IF_ID_WRITE,
  output logic                       IF_FLUSH,
  output logic                       ID_EX_BUBBLE,
  output logic                       EX_HOLD,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int                    MD_CNT_W    = $clog2(MD_LATENCY);
  // The cycle that detects the mul/div already holds EX once, and the final
  // release cycle is spent at count zero, hence the "-2".
  localparam logic [MD_CNT_W-1:0]   MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 2);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

  state_e                     state_q, state_d;
  logic [MD_CNT_W-1:0]        md_cnt_q, md_cnt_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                       load_use;

  load_use_detect #(
    .REG_ADDR_LEN (REG_ADDR_LEN)
  ) u_load_use_detect (
    .mem_read_i (id_ex_mem_read),
    .rd_i       (id_ex_rd),
    .rs1_i      (if_id_rs1),
    .rs2_i      (if_id_rs2),
    .uses_rs2_i (if_id_uses_rs2),
    .hazard_o   (load_use)
  );

  // Mealy control outputs and next-state; everything is forced quiet while
  // reset is asserted so the reset cycle itself drives no enables.
  always_comb begin
    imem_req     = 1'b0;
    PC_WRITE     = 1'b0;
    IF_ID_WRITE  = 1'b0;
    IF_FLUSH     = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    EX_HOLD      = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (branch_taken) begin
            // Redirect: squash both younger stages, no fetch this cycle.
            PC_WRITE     = 1'b1;
            IF_FLUSH     = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end else if (ex_is_muldiv) begin
            EX_HOLD  = 1'b1;
            state_d  = ST_MD_WAIT;
            md_cnt_d = MD_CNT_INIT;
          end else if (load_use) begin
            ID_EX_BUBBLE = 1'b1;
          end else begin
            imem_req = 1'b1;
            if (imem_ready) begin
              PC_WRITE    = 1'b1;
              IF_ID_WRITE = 1'b1;
            end else begin
              // ID still advances, so feed it a bubble rather than a copy.
              IF_FLUSH = 1'b1;
            end
          end
        end
        ST_MD_WAIT: begin
          if (md_cnt_q != '0) begin
            EX_HOLD  = 1'b1;
            md_cnt_d = md_cnt_q - 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  // Stall counter: front-end cycles without a PC update, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rst && (state_q != ST_INIT) && !PC_WRITE && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule : if_id_hazard_ctrl
`default_nettype wire

// File: tb/tb_if_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_hazard_ctrl
// Description : Directed self-checking bench for if_id_hazard_ctrl.
//               Output vector order: {imem_req, PC_WRITE, IF_ID_WRITE,
//               IF_FLUSH, ID_EX_BUBBLE, EX_HOLD}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_hazard_ctrl;

  localparam int REG_ADDR_LEN    = 5;
  localparam int MD_LATENCY      = 4;
  localparam int STALL_CNT_WIDTH = 4;

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_FETCH = 6'b111000;
  localparam logic [5:0] O_WAIT  = 6'b100100;
  localparam logic [5:0] O_LU    = 6'b000010;
  localparam logic [5:0] O_BR    = 6'b010110;
  localparam logic [5:0] O_HOLD  = 6'b000001;

  logic                       clk;
  logic                       rst;
  logic                       branch_taken;
  logic                       ex_is_muldiv;
  logic                       id_ex_mem_read;
  logic [REG_ADDR_LEN-1:0]    id_ex_rd;
  logic [REG_ADDR_LEN-1:0]    if_id_rs1;
  logic [REG_ADDR_LEN-1:0]    if_id_rs2;
  logic                       if_id_uses_rs2;
  logic                       imem_ready;
  logic                       imem_req;
  logic                       PC_WRITE;
  logic                       IF_ID_WRITE;
  logic                       IF_FLUSH;
  logic                       ID_EX_BUBBLE;
  logic                       EX_HOLD;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  if_id_hazard_ctrl #(
    .REG_ADDR_LEN    (REG_ADDR_LEN),
    .MD_LATENCY      (MD_LATENCY),
    .STALL_CNT_WIDTH (STALL_CNT_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_taken   (branch_taken),
    .ex_is_muldiv   (ex_is_muldiv),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .if_id_uses_rs2 (if_id_uses_rs2),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .PC_WRITE       (PC_WRITE),
    .IF_ID_WRITE    (IF_ID_WRITE),
    .IF_FLUSH       (IF_FLUSH),
    .ID_EX_BUBBLE   (ID_EX_BUBBLE),
    .EX_HOLD        (EX_HOLD),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {imem_req, PC_WRITE, IF_ID_WRITE, IF_FLUSH, ID_EX_BUBBLE, EX_HOLD};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Move to the next low phase; inputs change and outputs are sampled here.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch_taken   = 1'b0;
    ex_is_muldiv   = 1'b0;
    id_ex_mem_read = 1'b0;
    id_ex_rd       = '0;
    if_id_rs1      = '0;
    if_id_rs2      = '0;
    if_id_uses_rs2 = 1'b0;
    imem_ready     = 1'b1;
  endtask

  // Two reset cycles, one INIT cycle, ending in the first RUN cycle.
  task automatic do_reset(input string tag);
    clear_inputs();
    rst = 1'b1;
    next();
    chk({tag, "_rst0"}, 32'(outs()), 32'(O_IDLE));
    next();
    chk({tag, "_rst1"}, 32'(outs()), 32'(O_IDLE));
    rst = 1'b0;
    #1;
    chk({tag, "_init"}, 32'(outs()), 32'(O_IDLE));
    chk({tag, "_init_cnt"}, 32'(stall_count), 32'd0);
    next();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset and first RUN cycle.
    do_reset("reset");
    chk("run_fetch", 32'(outs()), 32'(O_FETCH));
    chk("run_cnt0", 32'(stall_count), 32'd0);
    next();

    // Load-use through rs2.
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rs1 = 5'd3;
    if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b1;
    #1 chk("lu_rs2", 32'(outs()), 32'(O_LU));
    next();
    chk("lu_cnt", 32'(stall_count), 32'd1);
    // Destination x0 never stalls.
    id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    #1 chk("lu_x0", 32'(outs()), 32'(O_FETCH));
    next();
    // rs2 match ignored when rs2 is unused.
    id_ex_rd = 5'd5; if_id_rs1 = 5'd6; if_id_rs2 = 5'd5; if_id_uses_rs2 = 1'b0;
    #1 chk("lu_nors2", 32'(outs()), 32'(O_FETCH));
    next();
    chk("lu_cnt_hold", 32'(stall_count), 32'd1);
    // Load-use through rs1.
    id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
    #1 chk("lu_rs1", 32'(outs()), 32'(O_LU));
    // Branch outranks load-use; no fetch.
    branch_taken = 1'b1;
    #1 chk("br_lu", 32'(outs()), 32'(O_BR));
    next();
    chk("br_cnt", 32'(stall_count), 32'd1);
    clear_inputs();
    #1 chk("br_after", 32'(outs()), 32'(O_FETCH));

    // Fetch wait: three not-ready cycles.
    do_reset("fw");
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("fw_wait%0d", i), 32'(outs()), 32'(O_WAIT));
      next();
    end
    chk("fw_cnt", 32'(stall_count), 32'd3);
    imem_ready = 1'b1;
    #1 chk("fw_ready", 32'(outs()), 32'(O_FETCH));

    // Mul/div: three hold cycles, one quiet cycle, then RUN.
    do_reset("md");
    ex_is_muldiv = 1'b1;
    #1 chk("md_hold0", 32'(outs()), 32'(O_HOLD));
    next();
    branch_taken = 1'b1;  // ignored while waiting
    #1 chk("md_hold1", 32'(outs()), 32'(O_HOLD));
    next();
    chk("md_hold2", 32'(outs()), 32'(O_HOLD));
    next();
    chk("md_release", 32'(outs()), 32'(O_IDLE));
    clear_inputs();
    #1 chk("md_release2", 32'(outs()), 32'(O_IDLE));
    next();
    chk("md_run", 32'(outs()), 32'(O_FETCH));
    chk("md_cnt", 32'(stall_count), 32'd4);

    // Saturation of the 4-bit counter.
    do_reset("sat");
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) next();
    chk("sat_cnt", 32'(stall_count), 32'd15);
    imem_ready = 1'b1;

    // Reset during MD_WAIT aborts the wait.
    do_reset("mdrst");
    ex_is_muldiv = 1'b1;
    next();
    chk("mdrst_hold", 32'(outs()), 32'(O_HOLD));
    rst = 1'b1;
    #1 chk("mdrst_rstcyc", 32'(outs()), 32'(O_IDLE));
    next();
    rst = 1'b0;
    #1 chk("mdrst_init", 32'(outs()), 32'(O_IDLE));
    chk("mdrst_cnt", 32'(stall_count), 32'd0);
    next();
    ex_is_muldiv = 1'b0;
    #1 chk("mdrst_run", 32'(outs()), 32'(O_FETCH));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_id_hazard_ctrl
`default_nettype wire
